// File: rtl/paddle_input_conditioner_pkg.sv
// Shared definitions for the paddle input path: button indices and debounce defaults.
package pong_input_pkg;

  localparam int IDX_UP_L   = 0;
  localparam int IDX_DOWN_L = 1;
  localparam int IDX_UP_R   = 2;
  localparam int IDX_DOWN_R = 3;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
  localparam int DEFAULT_CNT_W           = 18;

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchroniser into pixel_clk followed by a counting debouncer.
module button_debouncer
  import pong_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic pixel_clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d   = {sync_q[0], btn_raw};
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      // Only a disagreement lasting the full window flips the debounced level.
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/paddle_input_conditioner.sv
// Debounces the four paddle buttons, resolves up/down conflicts and drives the move outputs.
// Build option PADDLE_FRAME_STROBE_EN: defined gives one strobe per v_sync falling edge, undefined gives registered levels.
module paddle_input_conditioner
  import pong_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic       pixel_clk,
  input  logic       reset_n,
  input  logic       btn_up_L,
  input  logic       btn_down_L,
  input  logic       btn_up_R,
  input  logic       btn_down_R,
  input  logic       v_sync,
  output logic       up_L,
  output logic       down_L,
  output logic       up_R,
  output logic       down_R,
  output logic [3:0] btn_state
);

  logic [3:0] btn_raw;
  logic [3:0] stable;
  logic [3:0] move_res;
  logic [3:0] move_q, move_d;

  assign btn_raw = {btn_down_R, btn_up_R, btn_down_L, btn_up_L};

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .pixel_clk(pixel_clk),
      .reset_n  (reset_n),
      .btn_raw  (btn_raw[gi]),
      .stable   (stable[gi])
    );
  end

  // Opposing presses on one side cancel out.
  always_comb begin
    move_res             = '0;
    move_res[IDX_UP_L]   = stable[IDX_UP_L] & ~stable[IDX_DOWN_L];
    move_res[IDX_DOWN_L] = stable[IDX_DOWN_L] & ~stable[IDX_UP_L];
    move_res[IDX_UP_R]   = stable[IDX_UP_R] & ~stable[IDX_DOWN_R];
    move_res[IDX_DOWN_R] = stable[IDX_DOWN_R] & ~stable[IDX_UP_R];
  end

`ifdef PADDLE_FRAME_STROBE_EN
  logic vs_q, vs_d;
  logic frame_tick;

  always_comb begin
    vs_d       = v_sync;
    frame_tick = vs_q & ~v_sync;
    move_d     = frame_tick ? move_res : '0;
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q <= 1'b0;
    end else begin
      vs_q <= vs_d;
    end
  end
`else
  logic unused_v_sync;

  assign unused_v_sync = v_sync;

  always_comb begin
    move_d = move_res;
  end
`endif

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      move_q <= '0;
    end else begin
      move_q <= move_d;
    end
  end

  assign up_L      = move_q[IDX_UP_L];
  assign down_L    = move_q[IDX_DOWN_L];
  assign up_R      = move_q[IDX_UP_R];
  assign down_R    = move_q[IDX_DOWN_R];
  assign btn_state = stable;

endmodule

// File: tb/tb_paddle_input_conditioner.sv
// Directed bench for paddle_input_conditioner with DEBOUNCE_CYCLES=16, CNT_W=5.
module tb_paddle_input_conditioner;

  logic       pixel_clk  = 1'b0;
  logic       reset_n    = 1'b0;
  logic       btn_up_L   = 1'b0;
  logic       btn_down_L = 1'b0;
  logic       btn_up_R   = 1'b0;
  logic       btn_down_R = 1'b0;
  logic       v_sync     = 1'b1;
  logic       up_L, down_L, up_R, down_R;
  logic [3:0] btn_state;
  logic [3:0] mv;

  int checks = 0;
  int errors = 0;

  logic [3:0] bs_hist [0:31];
  logic [3:0] mv_hist [0:31];

  paddle_input_conditioner #(
    .DEBOUNCE_CYCLES(16),
    .CNT_W          (5)
  ) dut (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .btn_up_L  (btn_up_L),
    .btn_down_L(btn_down_L),
    .btn_up_R  (btn_up_R),
    .btn_down_R(btn_down_R),
    .v_sync    (v_sync),
    .up_L      (up_L),
    .down_L    (down_L),
    .up_R      (up_R),
    .down_R    (down_R),
    .btn_state (btn_state)
  );

  always #5 pixel_clk = ~pixel_clk;

  assign mv = {down_R, up_R, down_L, up_L};

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  // Records 25 cycles of history; returns the first index where bit b of btn_state equals lvl.
  task automatic record(input int b, input logic lvl, output int first);
    first = -1;
    for (int i = 1; i <= 25; i++) begin
      step();
      bs_hist[i] = btn_state;
      mv_hist[i] = mv;
      if (first < 0 && btn_state[b] === lvl) first = i;
    end
  endtask

`ifdef PADDLE_FRAME_STROBE_EN
  // Drives v_sync low for low_len cycles; strobe expected only in the cycle after the first low sample.
  task automatic frame_check(input string name, input logic [3:0] exp, input int low_len);
    int extra;
    v_sync = 1'b0;
    step();
    checks++;
    if (mv !== exp) begin
      errors++;
      $display("FAIL %s_strobe got %b want %b", name, mv, exp);
    end
    extra = 0;
    for (int i = 2; i <= low_len; i++) begin
      step();
      if (mv !== 4'b0000) extra++;
    end
    v_sync = 1'b1;
    step();
    step();
    if (mv !== 4'b0000) extra++;
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL %s_extra_strobes got %0d want 0", name, extra);
    end
    $display("frame %s strobe=%b extra=%0d", name, exp, extra);
  endtask
`else
  // v_sync keeps toggling; the level build must ignore it.
  initial begin
    forever begin
      repeat (40) step();
      v_sync = 1'b0;
      repeat (7) step();
      v_sync = 1'b1;
    end
  end
`endif

  task automatic test_reset();
    reset_n  = 1'b0;
    btn_up_L = 1'b1;
    repeat (3) step();
    checks++;
    if (btn_state !== 4'b0000) begin
      errors++;
      $display("FAIL reset_btn_state got %b want 0000", btn_state);
    end
    checks++;
    if (mv !== 4'b0000) begin
      errors++;
      $display("FAIL reset_moves got %b want 0000", mv);
    end
    $display("reset btn_state=%b moves=%b", btn_state, mv);
  endtask

  task automatic test_latency();
    int first;
    reset_n = 1'b1;
    record(0, 1'b1, first);
    checks++;
    if (first !== 18) begin
      errors++;
      $display("FAIL latency_up_L got %0d want 18", first);
    end
`ifdef PADDLE_FRAME_STROBE_EN
    checks++;
    if (mv_hist[19] !== 4'b0000) begin
      errors++;
      $display("FAIL no_tick_moves got %b want 0000", mv_hist[19]);
    end
    frame_check("held_up_L", 4'b0001, 4);
    frame_check("held_up_L_again", 4'b0001, 10);
`else
    checks++;
    if (mv_hist[18] !== 4'b0000) begin
      errors++;
      $display("FAIL level_before got %b want 0000", mv_hist[18]);
    end
    checks++;
    if (mv_hist[19] !== 4'b0001) begin
      errors++;
      $display("FAIL level_after got %b want 0001", mv_hist[19]);
    end
`endif
    $display("latency up_L rise at cycle %0d", first);
  endtask

  task automatic test_glitch();
    logic seen_state, seen_out;
    seen_state = 1'b0;
    seen_out   = 1'b0;
    for (int i = 0; i < 53; i++) begin
      btn_down_R = (i < 10) || (i >= 13 && i < 23);
      step();
      if (btn_state[3] !== 1'b0) seen_state = 1'b1;
      if (down_R !== 1'b0) seen_out = 1'b1;
    end
    checks++;
    if (seen_state !== 1'b0) begin
      errors++;
      $display("FAIL glitch_btn_state got 1 want 0");
    end
    checks++;
    if (seen_out !== 1'b0) begin
      errors++;
      $display("FAIL glitch_down_R got 1 want 0");
    end
`ifdef PADDLE_FRAME_STROBE_EN
    frame_check("after_glitch", 4'b0001, 3);
`endif
    $display("glitch btn_state_seen=%b down_R_seen=%b", seen_state, seen_out);
  endtask

  task automatic test_conflict();
    int first;
    btn_down_L = 1'b1;
    repeat (25) step();
    checks++;
    if (btn_state !== 4'b0011) begin
      errors++;
      $display("FAIL conflict_state got %b want 0011", btn_state);
    end
`ifdef PADDLE_FRAME_STROBE_EN
    frame_check("conflict", 4'b0000, 3);
`else
    checks++;
    if (mv !== 4'b0000) begin
      errors++;
      $display("FAIL conflict_moves got %b want 0000", mv);
    end
`endif
    btn_down_L = 1'b0;
    record(1, 1'b0, first);
    checks++;
    if (first !== 18) begin
      errors++;
      $display("FAIL release_down_L got %0d want 18", first);
    end
`ifdef PADDLE_FRAME_STROBE_EN
    frame_check("after_conflict", 4'b0001, 3);
`else
    checks++;
    if (mv_hist[18] !== 4'b0000 || mv_hist[19] !== 4'b0001) begin
      errors++;
      $display("FAIL conflict_resolve got %b,%b want 0000,0001", mv_hist[18], mv_hist[19]);
    end
`endif
    $display("conflict release down_L fell at cycle %0d", first);
  endtask

  task automatic test_long_vsync();
    btn_up_R = 1'b1;
    repeat (25) step();
`ifdef PADDLE_FRAME_STROBE_EN
    frame_check("long_vsync", 4'b0101, 50);
`else
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
        step();
        if (mv !== 4'b0101) bad++;
      end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL level_steady got %0d bad cycles want 0", bad);
      end
    end
`endif
    $display("long_vsync btn_state=%b", btn_state);
  endtask

  task automatic test_reset_mid();
    int first;
    btn_up_R = 1'b0;
    repeat (25) step();
    btn_up_R = 1'b1;
    repeat (12) step();
    reset_n = 1'b0;
    #1;
    checks++;
    if (btn_state !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_state got %b want 0000", btn_state);
    end
    checks++;
    if (mv !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_moves got %b want 0000", mv);
    end
    repeat (3) step();
    reset_n = 1'b1;
    record(2, 1'b1, first);
    checks++;
    if (first !== 18) begin
      errors++;
      $display("FAIL midreset_latency got %0d want 18", first);
    end
    checks++;
    if (bs_hist[18] !== 4'b0101) begin
      errors++;
      $display("FAIL midreset_state_after got %b want 0101", bs_hist[18]);
    end
`ifndef PADDLE_FRAME_STROBE_EN
    checks++;
    if (mv_hist[19] !== 4'b0101) begin
      errors++;
      $display("FAIL midreset_level got %b want 0101", mv_hist[19]);
    end
`endif
    $display("reset_mid up_R rise at cycle %0d", first);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_conflict();
    test_long_vsync();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/paddle_input_conditioner.md
# paddle_input_conditioner

Conditions the four raw paddle push-buttons before they reach the image generator: synchronises each asynchronous input to `pixel_clk`, debounces it, resolves conflicting up/down presses, and emits one move strobe per video frame, aligned to vertical sync. Sits between the board/AXI button inputs and the `up_L`/`down_L`/`up_R`/`down_R` inputs of the image generator inside the pong top level.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive cycles a synchronised input must differ from its debounced state before that state flips (10 ms at 25 MHz); legal range is 2..2^CNT_W.
- `CNT_W`, default 18: debounce counter width; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.
- `pixel_clk` in 1: the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `btn_up_L`, `btn_down_L`, `btn_up_R`, `btn_down_R` in 1 each: raw active-high buttons, asynchronous to `pixel_clk`.
- `v_sync` in 1: active-low vertical sync from the VGA controller, synchronous to `pixel_clk`.
- `up_L`, `down_L`, `up_R`, `down_R` out 1 each: move commands to the image generator.
- `btn_state` out 4: debounced levels, packed as {down_R, up_R, down_L, up_L}.

## Operation
- Synchroniser: 2-flop chain per button, with reset value 0.
- Debouncer, per button: a `stable` register and a counter.
  - Counter clears whenever sync == stable.
  - While sync != stable, the counter increments.
  - On the cycle the counter equals DEBOUNCE_CYCLES-1 while sync still differs: stable <= sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES restarts the count; stable does not change.
- Conflict resolution, per side: move_up = stable_up & ~stable_down; move_down = stable_down & ~stable_up. Both pressed gives no motion.
- Frame tick:
  - Register `v_sync` into `vs_d`.
  - frame_tick = vs_d & ~v_sync, i.e. the falling edge, start of the sync pulse.
  - Exactly one tick per frame; a `v_sync` held low produces no further ticks.
- Outputs: registered. On frame_tick, each move output takes its resolved move value; on all other cycles, move outputs are 0.
- `btn_state` is the `stable` registers directly.
- Reset, including mid-operation: asynchronously clears synchronisers, stable, counters, `vs_d` and outputs. A button held through reset release must complete a full debounce before it is seen.

## Timing
- Reset value of every output: 0.
- Press-to-`btn_state` latency: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles.
- Strobe timing: if cycle N is the first cycle `pixel_clk` samples `v_sync` low, the move strobe is high during cycle N+1 for exactly one cycle.
- A `stable` update at the same edge as frame_tick is not used for that frame's strobe; the pre-update value applies.
- Release: the strobe stops at the first frame tick after `stable` drops.

## Configuration
- `PADDLE_FRAME_STROBE_EN`:
  - Defined: frame-gated single-cycle strobes, as described above.
  - Undefined: `v_sync` is ignored and `vs_d` is not built. Move outputs are registered levels equal to the resolved move values every cycle, with 1 cycle of latency after `stable`.
- `btn_state` behaves identically in both builds.

## Structure
- Shared package `pong_input_pkg` holds:
  - Button index constants: IDX_UP_L=0, IDX_DOWN_L=1, IDX_UP_R=2, IDX_DOWN_R=3.
  - Default DEBOUNCE_CYCLES and CNT_W.
- Sub-module `button_debouncer` (synchroniser + counter + stable register, with parameters DEBOUNCE_CYCLES and CNT_W), instantiated 4 times.
- The top of the block holds conflict resolution, frame-edge detection and output registers.

## Test plan
Simulation uses DEBOUNCE_CYCLES=16 and CNT_W=5.
- Reset then idle: hold `btn_up_L`=1 and pulse `v_sync` low every 100 cycles -> all outputs 0 until the bit for `up_L` in `btn_state` rises 18 cycles after release; thereafter `up_L` is a 1-cycle pulse, 1 cycle after each `v_sync` falling edge.
- Glitch rejection: `btn_down_R` high for 10 cycles, low for 3, high for 10 -> `btn_state` stays 0 and `down_R` is never asserted.
- Conflict: `btn_up_L` and `btn_down_L` both held and debounced -> `up_L` = `down_L` = 0 at every frame tick, `btn_state`=4'b0011. Release `btn_down_L` -> `up_L` strobes from the first tick after its debounce completes.
- Long `v_sync` low (50 cycles) with `btn_up_R` debounced -> exactly one `up_R` pulse.
- Reset asserted mid-debounce (counter = 10) with the button held -> outputs 0 immediately; after release, 18 more cycles before `btn_state` rises.
- With `PADDLE_FRAME_STROBE_EN` undefined -> a held, debounced `btn_down_L` gives `down_L`=1 continuously, 1 cycle after `btn_state` rises, independent of `v_sync`.
